// File: rtl/eindopdracht_pio_leds_pulse.sv
// Avalon-MM output PIO driving LEDs, with set/clear registers and a one-shot
// pulse engine that inverts selected bits for a programmed number of cycles.
module eindopdracht_pio_leds_pulse #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned CNT_W       = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_active
);

  localparam logic [DATA_WIDTH-1:0] DATA_RST = DATA_WIDTH'(RESET_VALUE);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_LEN    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLR    = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [DATA_WIDTH-1:0]   data_next;
  logic [DATA_WIDTH-1:0]   mask_reg;
  logic [CNT_W-1:0]        len_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [31:0]             rd_next;
  logic [63:0]             status_wide;

  logic                    wr;
  logic                    wr_data;
  logic                    wr_len;
  logic                    wr_mask;
  logic                    wr_status;
  logic                    wr_set;
  logic                    wr_clr;
  logic                    busy;
  logic                    start_ok;
  logic [DATA_WIDTH-1:0]   wd_data;
  logic [CNT_W-1:0]        wd_len;

  assign wr        = chipselect & ~write_n;
  assign wr_data   = wr && (address == ADDR_DATA);
  assign wr_len    = wr && (address == ADDR_LEN);
  assign wr_mask   = wr && (address == ADDR_MASK);
  assign wr_status = wr && (address == ADDR_STATUS);
  assign wr_set    = wr && (address == ADDR_SET);
  assign wr_clr    = wr && (address == ADDR_CLR);

  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_len    = writedata[CNT_W-1:0];

  assign busy         = (state == ST_PULSE);
  assign pulse_active = busy;

  // A mask write only launches a pulse when both mask and length are non-zero.
  assign start_ok = (wd_data != '0) && (len_reg != '0);

  // Per-bit data update and output inversion; out_port depends only on flops.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      always_comb begin
        data_next[gi] = data_reg[gi];
        if (wr_data) begin
          data_next[gi] = wd_data[gi];
        end else if (wr_set) begin
          data_next[gi] = data_reg[gi] | wd_data[gi];
        end else if (wr_clr) begin
          data_next[gi] = data_reg[gi] & ~wd_data[gi];
        end
      end

      assign out_port[gi] = data_reg[gi] ^ (busy & mask_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= DATA_RST;
    end else begin
      data_reg <= data_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_reg <= '0;
    end else if (wr_len) begin
      len_reg <= wd_len;
    end
  end

  // Pulse engine: cnt_reg holds the number of inversion cycles still to come.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt_reg  <= '0;
      mask_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_mask) begin
            mask_reg <= wd_data;
            if (start_ok) begin
              state   <= ST_PULSE;
              cnt_reg <= len_reg;
            end
          end
        end
        ST_PULSE: begin
          if (wr_mask) begin
            // A restart takes priority over an expiry on the same edge.
            mask_reg <= wd_data;
            if (start_ok) begin
              cnt_reg <= len_reg;
            end else begin
              state   <= ST_IDLE;
              cnt_reg <= '0;
            end
          end else if (wr_status) begin
            state   <= ST_IDLE;
            cnt_reg <= '0;
          end else if (cnt_reg <= CNT_W'(1)) begin
            state   <= ST_IDLE;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt_reg <= '0;
        end
      endcase
    end
  end

  // Count sits at bit 8 upward; bits beyond 31 fall off for very wide counters.
  assign status_wide = {{(56 - CNT_W){1'b0}}, cnt_reg, 7'd0, busy};

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:   rd_next[DATA_WIDTH-1:0] = data_reg;
      ADDR_LEN:    rd_next[CNT_W-1:0]      = len_reg;
      ADDR_MASK:   rd_next[DATA_WIDTH-1:0] = mask_reg;
      ADDR_STATUS: rd_next                 = status_wide[31:0];
      default:     rd_next                 = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, writedata, status_wide[63:32]};

endmodule

// File: tb/tb_eindopdracht_pio_leds_pulse.sv
// Randomised scoreboard bench for the LED PIO: a cycle-level model predicts
// out_port, pulse_active and readdata; a monitor compares one entry per cycle.
module tb_eindopdracht_pio_leds_pulse;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_active;

  eindopdracht_pio_leds_pulse #(
    .DATA_WIDTH (8),
    .RESET_VALUE(0),
    .CNT_W      (24)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .out_port    (out_port),
    .pulse_active(pulse_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  out;
    logic        act;
    logic [31:0] rd;
    int          idx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  // Model state: rem_cycles is the number of cycles of inversion still ahead.
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  logic [23:0] m_len;
  int unsigned rem_cycles;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_data     = 8'h00;
    m_mask     = 8'h00;
    m_len      = 24'd0;
    rem_cycles = 0;
  endtask

  // Drive one bus cycle and push what the DUT must show after the next edge.
  task automatic bus_cycle(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] rd;
    int unsigned nrem;
    @(negedge clk);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    case (a)
      3'd0:    rd = {24'd0, m_data};
      3'd1:    rd = {8'd0, m_len};
      3'd2:    rd = {24'd0, m_mask};
      3'd3:    rd = (32'(rem_cycles) << 8) | 32'(rem_cycles != 0);
      default: rd = 32'd0;
    endcase
    nrem = (rem_cycles > 0) ? rem_cycles - 1 : 0;
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[7:0];
        3'd1: m_len = wd[23:0];
        3'd2: begin
          m_mask = wd[7:0];
          nrem = (m_mask != 0 && m_len != 0) ? int'(m_len) : 0;
        end
        3'd3: nrem = 0;
        3'd4: m_data = m_data | wd[7:0];
        3'd5: m_data = m_data & ~wd[7:0];
        default: ;
      endcase
    end
    rem_cycles = nrem;
    e.out = m_data ^ ((rem_cycles != 0) ? m_mask : 8'h00);
    e.act = (rem_cycles != 0);
    e.rd  = rd;
    e.idx = txn;
    txn++;
    sb_q.push_back(e);
    $display("txn %0d cs=%0b wn=%0b addr=%0d wd=0x%08h exp_out=0x%02h exp_act=%0b exp_rd=0x%0h",
             e.idx, cs, wn, a, wd, e.out, e.act, e.rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    bus_cycle(1'b1, 1'b0, a, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    bus_cycle(1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) bus_cycle(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom);
  endtask

  // Wait until the last pushed expectation has been compared.
  task automatic drain();
    @(posedge clk);
    #3;
  endtask

  // Monitor: compares one queued expectation per clock, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check32("out_port", {24'd0, out_port}, {24'd0, e.out});
        check32("pulse_active", {31'd0, pulse_active}, {31'd0, e.act});
        check32("readdata", readdata, e.rd);
      end
    end
  end

  initial begin
    model_reset();
    #12;
    check32("reset_out_port", {24'd0, out_port}, 32'h0);
    check32("reset_pulse_active", {31'd0, pulse_active}, 32'h0);
    check32("reset_readdata", readdata, 32'h0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    rd(3'd3);

    wr(3'd0, 32'hA5);
    wr(3'd4, 32'h0F);
    wr(3'd5, 32'h81);
    rd(3'd0);
    drain();
    check32("set_clear_result", {24'd0, out_port}, 32'h2E);

    wr(3'd0, 32'h00);
    wr(3'd1, 32'd5);
    wr(3'd2, 32'h03);
    idle(7);

    wr(3'd1, 32'd10);
    wr(3'd2, 32'h01);
    idle(3);
    wr(3'd2, 32'h80);
    idle(12);

    wr(3'd1, 32'd100);
    wr(3'd2, 32'hFF);
    idle(2);
    rd(3'd3);
    wr(3'd3, 32'd0);
    idle(2);
    rd(3'd3);

    wr(3'd1, 32'd0);
    wr(3'd2, 32'h01);
    idle(3);
    rd(3'd2);

    wr(3'd1, 32'd1);
    wr(3'd2, 32'h40);
    idle(3);

    // Restart landing on the expiry edge.
    wr(3'd1, 32'd3);
    wr(3'd2, 32'h04);
    idle(2);
    wr(3'd2, 32'h08);
    idle(5);

    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd1 && $urandom_range(0, 9) != 0) wd = $urandom_range(0, 12);
      bus_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, wd);
    end

    // Asynchronous reset in the middle of a long pulse.
    wr(3'd0, 32'h00);
    wr(3'd1, 32'd50);
    wr(3'd2, 32'hF0);
    idle(2);
    drain();
    check32("mid_pulse_busy", {31'd0, pulse_active}, 32'h1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b0;
    #1;
    check32("async_reset_out_port", {24'd0, out_port}, 32'h0);
    check32("async_reset_pulse_active", {31'd0, pulse_active}, 32'h0);
    check32("async_reset_readdata", readdata, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    model_reset();
    rd(3'd3);
    rd(3'd2);
    rd(3'd1);
    idle(2);

    drain();
    repeat (3) @(posedge clk);
    check32("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
